// File: rtl/hdmi_word_align_if.sv
// Aligner bus: raw words in, aligned words, lock and offset out.
// With HDMI_ALIGN_STATS_EN it also carries i_clr_stats / o_slips.
interface hdmi_word_align_if;
  logic       i_ce;
  logic [9:0] i_raw;
  logic       o_valid;
  logic [9:0] o_word;
  logic       o_locked;
  logic [3:0] o_shift;
`ifdef HDMI_ALIGN_STATS_EN
  logic       i_clr_stats;
  logic [7:0] o_slips;

  modport master (
    output i_ce, i_raw, i_clr_stats,
    input  o_valid, o_word, o_locked,
    input  o_shift, o_slips
  );
  modport slave (
    input  i_ce, i_raw, i_clr_stats,
    output o_valid, o_word, o_locked,
    output o_shift, o_slips
  );
`else
  modport master (
    output i_ce, i_raw,
    input  o_valid, o_word, o_locked,
    input  o_shift
  );
  modport slave (
    input  i_ce, i_raw,
    output o_valid, o_word, o_locked,
    output o_shift
  );
`endif
endinterface

// File: rtl/hdmi_word_align.sv
// TMDS word aligner: searches the 10 bit offsets for control tokens
// and emits boundary-aligned words one word behind the input.
// Ports: i_clk, i_reset (async, active-high), bus (slave):
//   i_ce/i_raw in; o_valid/o_word/o_locked/o_shift out.
// Option HDMI_ALIGN_STATS_EN adds i_clr_stats and o_slips.
module hdmi_word_align #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 65536
) (
  input logic              i_clk,
  input logic              i_reset,
  hdmi_word_align_if.slave bus
);
  localparam int HW = $clog2(LOCK_COUNT) + 1;
  localparam int TW = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int MW = $clog2(LOSS_TIMEOUT) + 1;

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state, state_n;
  logic [9:0]    prev;
  logic [HW-1:0] hits, hits_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [MW-1:0] miss, miss_n;
  logic [3:0]    shift, shift_n;
  logic          valid;
  logic [9:0]    word;
  logic [19:0]   h;
  logic [9:0]    cand;
  logic          tok;

  always_comb begin
    h    = {prev, bus.i_raw};
    // h[19-s:10-s]: offset 0 passes prev unchanged
    cand = 10'(h >> (5'd10 - {1'b0, shift}));
    tok  = cand inside {10'h354, 10'h0AB,
                        10'h154, 10'h2AB};
  end

  always_comb begin
    state_n = state;
    hits_n  = hits;
    tmo_n   = tmo;
    miss_n  = miss;
    shift_n = shift;
    if (bus.i_ce) begin
      unique case (state)
        SEARCH: begin
          // A completing hit beats a coincident timeout
          if (tok && hits == HW'(LOCK_COUNT - 1)) begin
            state_n = LOCKED;
            hits_n  = hits + 1'b1;
            miss_n  = '0;
          end else if (tmo == TW'(SEARCH_TIMEOUT - 1)) begin
            shift_n = (shift == 4'd9) ? 4'd0
                                      : shift + 4'd1;
            hits_n  = '0;
            tmo_n   = '0;
          end else begin
            if (tmo != '1) tmo_n = tmo + 1'b1;
            if (tok && hits != '1) hits_n = hits + 1'b1;
          end
        end
        LOCKED: begin
          if (tok) begin
            miss_n = '0;
          end else if (miss == MW'(LOSS_TIMEOUT - 1)) begin
            // Keep shift: search resumes at last good offset
            state_n = SEARCH;
            hits_n  = '0;
            tmo_n   = '0;
          end else if (miss != '1) begin
            miss_n = miss + 1'b1;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= SEARCH;
      prev  <= '0;
      hits  <= '0;
      tmo   <= '0;
      miss  <= '0;
      shift <= '0;
      valid <= 1'b0;
      word  <= '0;
    end else begin
      state <= state_n;
      hits  <= hits_n;
      tmo   <= tmo_n;
      miss  <= miss_n;
      shift <= shift_n;
      valid <= bus.i_ce;
      if (bus.i_ce) begin
        prev <= bus.i_raw;
        word <= cand;
      end
    end
  end

  assign bus.o_valid  = valid;
  assign bus.o_word   = word;
  assign bus.o_locked = (state == LOCKED);
  assign bus.o_shift  = shift;

`ifdef HDMI_ALIGN_STATS_EN
  logic [7:0] slips;
  logic       slip;

  assign slip = (shift_n != shift) ||
                (state == LOCKED && state_n == SEARCH);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      slips <= '0;
    end else if (bus.i_clr_stats) begin
      slips <= '0;
    end else if (slip && slips != '1) begin
      slips <= slips + 8'd1;
    end
  end

  assign bus.o_slips = slips;
`endif
endmodule

// File: tb/tb_hdmi_word_align.sv
// Directed bench for hdmi_word_align (small timeouts).
// Checks reset, zero/3/5/9 offsets, wrap, gaps, lock vs timeout.
module tb_hdmi_word_align;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  int   lock_at;

  always #5 clk = ~clk;

  hdmi_word_align_if bus ();

  hdmi_word_align #(
    .LOCK_COUNT     (8),
    .SEARCH_TIMEOUT (16),
    .LOSS_TIMEOUT   (32)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input logic ce,
                      input logic [9:0] raw);
    @(negedge clk);
    bus.i_ce  = ce;
    bus.i_raw = raw;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    bus.i_ce  = 1'b0;
    bus.i_raw = '0;
`ifdef HDMI_ALIGN_STATS_EN
    bus.i_clr_stats = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raw word of a repeating token stream delayed by d bits
  function automatic logic [9:0] dly(input logic [9:0] t,
                                     input int d);
    logic [19:0] w;
    w = {t, t};
    w = w >> d;
    return w[9:0];
  endfunction

  // Feed n words of one pattern, note the first locked word
  task automatic run(input logic [9:0] raw, input int n);
    lock_at = 0;
    for (int k = 1; k <= n; k++) begin
      step(1'b1, raw);
      if (bus.o_locked && lock_at == 0) lock_at = k;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_ce  = 1'b0;
    bus.i_raw = '0;
`ifdef HDMI_ALIGN_STATS_EN
    bus.i_clr_stats = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid",  bus.o_valid,  0);
    chk("rst_word",   bus.o_word,   0);
    chk("rst_locked", bus.o_locked, 0);
    chk("rst_shift",  bus.o_shift,  0);

    // Zero offset: first word shows prev=0, 8 hits after
    step(1'b1, 10'h354);
    chk("zo_valid", bus.o_valid, 1);
    for (int k = 2; k <= 8; k++) step(1'b1, 10'h354);
    chk("zo_prelock", bus.o_locked, 0);
    step(1'b1, 10'h354);
    chk("zo_lock",  bus.o_locked, 1);
    chk("zo_word",  bus.o_word,   10'h354);
    chk("zo_shift", bus.o_shift,  0);
    repeat (4) step(1'b1, 10'h354);
    chk("zo_steady", bus.o_word, 10'h354);

    // Gapped ce: tokens on gaps must not count
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(k[0], 10'h354);
      if (k == 15) chk("gap_l15", bus.o_locked, 0);
      if (k == 16) chk("gap_v16", bus.o_valid, 0);
      if (k == 16) chk("gap_l16", bus.o_locked, 0);
    end
    chk("gap_lock", bus.o_locked, 1);
    step(1'b0, 10'h0AB);
    chk("gap_hold", bus.o_word, 10'h354);
    chk("gap_nv",   bus.o_valid, 0);

    // 8th hit on the timeout word: lock, no slip
    do_reset();
    for (int k = 1; k <= 7; k++) step(1'b1, 10'h000);
    for (int k = 8; k <= 15; k++) step(1'b1, 10'h354);
    chk("sim_l15", bus.o_locked, 0);
    step(1'b1, 10'h354);
    chk("sim_lock",  bus.o_locked, 1);
    chk("sim_shift", bus.o_shift,  0);
`ifdef HDMI_ALIGN_STATS_EN
    chk("sim_slips", bus.o_slips, 0);
`endif

    // Offset 3: slips at 0,1,2 then 8 hits
    do_reset();
    run(dly(10'h0AB, 3), 60);
    chk("o3_lockat", lock_at, 56);
    chk("o3_shift",  bus.o_shift, 3);
    chk("o3_word",   bus.o_word,  10'h0AB);
`ifdef HDMI_ALIGN_STATS_EN
    chk("o3_slips", bus.o_slips, 3);
`endif

    // Wrap: lock at 9, lose lock, time out to 0
    do_reset();
    run(dly(10'h2AB, 9), 152);
    chk("w_lockat", lock_at, 152);
    chk("w_shift9", bus.o_shift, 9);
    for (int k = 1; k <= 31; k++) step(1'b1, 10'h000);
    chk("w_hold", bus.o_locked, 1);
    step(1'b1, 10'h000);
    chk("w_lost",  bus.o_locked, 0);
    chk("w_keep9", bus.o_shift,  9);
    for (int k = 1; k <= 15; k++) step(1'b1, 10'h000);
    chk("w_still9", bus.o_shift, 9);
    step(1'b1, 10'h000);
    chk("w_wrap0", bus.o_shift, 0);
`ifdef HDMI_ALIGN_STATS_EN
    chk("w_slips", bus.o_slips, 11);
    @(negedge clk);
    bus.i_clr_stats = 1'b1;
    bus.i_ce = 1'b0;
    @(negedge clk);
    bus.i_clr_stats = 1'b0;
    chk("w_clr", bus.o_slips, 0);
`endif

    // Async reset while locked at offset 5
    do_reset();
    run(dly(10'h354, 5), 88);
    chk("r5_lockat", lock_at, 88);
    chk("r5_shift",  bus.o_shift, 5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("r5_locked", bus.o_locked, 0);
    chk("r5_shift0", bus.o_shift,  0);
    chk("r5_valid",  bus.o_valid,  0);
    chk("r5_word",   bus.o_word,   0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
